// File: rtl/moore_seq_detector_p.sv
// Programmable Moore serial sequence detector.
// Pattern and overlap mode are reloadable at run time. Next-state logic is a
// KMP-style failure-function table that is rebuilt combinationally from the
// live pattern register. The block also keeps a saturating count of matches.
module moore_seq_detector_p #(
  parameter int             N        = 4,
  parameter logic [N-1:0]   PATTERN  = 4'b1101,
  parameter bit             OVERLAP0 = 1'b1,
  parameter int             CNT_W    = 8,
  localparam int            SW       = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             x,
  input  logic             cfg_we,
  input  logic [N-1:0]     cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             clr_count,
  output logic             match,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [SW-1:0] ST_FULL = SW'(N);

  logic [N-1:0]     pat_q;
  logic             ovl_q;
  logic [SW-1:0]    state_q, state_nxt, base;
  logic             match_q, match_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             adv;
  logic [SW-1:0]    nxt0 [0:N];
  logic [SW-1:0]    nxt1 [0:N];

  // Longest pattern prefix that is a suffix of (prefix_k, xb).
  // The bit at position i of prefix_k is p[N-1-i], so the sequence being
  // tested is built entirely from the pattern itself plus the new bit.
  function automatic logic [SW-1:0] kmp_next(input logic [N-1:0] p,
                                             input int k, input logic xb);
    logic [SW-1:0] r;
    logic          ok;
    r = '0;
    for (int j = 1; j <= N; j++) begin
      if (j <= k + 1) begin
        ok = (p[N-j] == xb);
        for (int m = 0; m < N - 1; m++)
          if (m < j - 1)
            if (p[N-1-m] != p[N-1-(k+1-j+m)]) ok = 1'b0;
        if (ok) r = SW'(j);
      end
    end
    return r;
  endfunction

  // Transition table for every state and both input values, built from the live pattern.
  always_comb begin
    for (int k = 0; k <= N; k++) begin
      nxt0[k] = kmp_next(pat_q, k, 1'b0);
      nxt1[k] = kmp_next(pat_q, k, 1'b1);
    end
  end

  // Next state. cfg_we wins over en. Illegal encodings fall back to 0.
  // When overlap is off, a full match restarts from the empty prefix.
  always_comb begin
    base      = (state_q == ST_FULL && !ovl_q) ? '0 : state_q;
    adv       = 1'b0;
    state_nxt = state_q;
    if (state_q > ST_FULL) begin
      state_nxt = '0;
    end else if (cfg_we) begin
      state_nxt = '0;
    end else if (en) begin
      adv       = 1'b1;
      state_nxt = x ? nxt1[base] : nxt0[base];
    end
  end

  // Outputs for the next cycle. match follows state==N. The count bumps on
  // every consumed bit that lands in N, saturates, and is overridden by clear.
  always_comb begin
    match_nxt = (state_nxt == ST_FULL);
    cnt_nxt   = cnt_q;
    if (clr_count)
      cnt_nxt = '0;
    else if (adv && state_nxt == ST_FULL && cnt_q != '1)
      cnt_nxt = cnt_q + CNT_W'(1);
  end

  // State, output and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      pat_q   <= PATTERN;
      ovl_q   <= OVERLAP0;
    end else begin
      state_q <= state_nxt;
      match_q <= match_nxt;
      cnt_q   <= cnt_nxt;
      if (cfg_we) begin
        pat_q <= cfg_pattern;
        ovl_q <= cfg_overlap;
      end
    end
  end

  assign match       = match_q;
  assign state       = state_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_moore_seq_detector_p.sv
// Bench for moore_seq_detector_p. Two instances share the same inputs: the
// default one with an 8-bit counter, and a second one with a 2-bit counter
// that exercises saturation. The reference model keeps the recent consumed
// bits since the last restart and finds the longest matching prefix directly.
module tb_moore_seq_detector_p;
  localparam int N = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       en = 1'b0, x = 1'b0, cfg_we = 1'b0, cfg_overlap = 1'b0, clr_count = 1'b0;
  logic [3:0] cfg_pattern = 4'b0;
  logic [2:0] state, state2;
  logic       match, match2;
  logic [7:0] match_count;
  logic [1:0] match_count2;
  logic [17:0] obs;

  int vecs = 0, miss = 0;

  bit         hist[$];
  logic [3:0] m_pat;
  bit         m_ovl;
  int         m_cnt;

  moore_seq_detector_p dut (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .match(match), .state(state), .match_count(match_count));

  moore_seq_detector_p #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .match(match2), .state(state2), .match_count(match_count2));

  always #5 clk = ~clk;

  assign obs = {state, match, match_count, match_count2, state2, match2};

  function automatic void model_reset();
    hist.delete();
    m_pat = 4'b1101;
    m_ovl = 1'b1;
    m_cnt = 0;
  endfunction

  // Longest j such that the last j consumed bits equal the first j pattern bits.
  function automatic int ref_state();
    int best;
    bit ok;
    best = 0;
    for (int j = 1; j <= N; j++) begin
      if (j <= hist.size()) begin
        ok = 1'b1;
        for (int m = 0; m < j; m++)
          if (hist[hist.size()-j+m] != m_pat[N-1-m]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  function automatic logic [17:0] exp_vec();
    int s, c8, c2;
    s  = ref_state();
    c8 = (m_cnt > 255) ? 255 : m_cnt;
    c2 = (m_cnt > 3) ? 3 : m_cnt;
    return {s[2:0], s == N, c8[7:0], c2[1:0], s[2:0], s == N};
  endfunction

  function automatic void model_edge();
    if (cfg_we) begin
      m_pat = cfg_pattern;
      m_ovl = cfg_overlap;
      hist.delete();
    end else if (en) begin
      if (ref_state() == N && !m_ovl) hist.delete();
      hist.push_back(x);
      if (hist.size() > N) void'(hist.pop_front());
      if (ref_state() == N) m_cnt++;
    end
    if (clr_count) m_cnt = 0;
  endfunction

  // One clock cycle: apply inputs, let the edge happen, update the model, settle.
  task automatic cyc(input logic e, input logic xv, input logic we = 1'b0,
                     input logic [3:0] pv = 4'b0, input logic ov = 1'b0,
                     input logic clr = 1'b0);
    en = e; x = xv; cfg_we = we; cfg_pattern = pv; cfg_overlap = ov; clr_count = clr;
    @(posedge clk);
    model_edge();
    #1;
    en = 1'b0; cfg_we = 1'b0; clr_count = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    vecs++;
    if (obs !== 18'h0) begin
      miss++; $display("FAIL reset: got %h expected %h", obs, 18'h0);
    end
    #6 rst_n = 1'b1;
  endtask

  task automatic test_overlap();
    bit b[7] = '{1,1,0,1,1,0,1};
    int e[7] = '{1,2,3,4,2,3,4};
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, b[i]);
      vecs++;
      if (obs !== exp_vec() || state !== 3'(e[i])) begin
        miss++; $display("FAIL overlap[%0d]: got %h expected %h (state %0d)", i, obs, exp_vec(), e[i]);
      end
    end
    vecs++;
    if (match_count !== 8'd2) begin
      miss++; $display("FAIL overlap_count: got %0d expected 2", match_count);
    end
  endtask

  task automatic test_no_overlap();
    bit b[7] = '{1,1,0,1,1,0,1};
    int e[7] = '{1,2,3,4,1,0,1};
    cyc(1'b0, 1'b0, 1'b1, 4'b1101, 1'b0);
    vecs++;
    if (obs !== exp_vec()) begin
      miss++; $display("FAIL no_overlap_cfg: got %h expected %h", obs, exp_vec());
    end
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, b[i]);
      vecs++;
      if (obs !== exp_vec() || state !== 3'(e[i])) begin
        miss++; $display("FAIL no_overlap[%0d]: got %h expected %h (state %0d)", i, obs, exp_vec(), e[i]);
      end
    end
    vecs++;
    if (match_count !== 8'd3) begin
      miss++; $display("FAIL no_overlap_count: got %0d expected 3", match_count);
    end
  endtask

  task automatic test_gaps();
    int e[7] = '{1,2,3,4,4,4,4};
    logic [17:0] p;
    cyc(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b1);
      vecs++;
      if (obs !== exp_vec() || state !== 3'(e[i])) begin
        miss++; $display("FAIL ones[%0d]: got %h expected %h (state %0d)", i, obs, exp_vec(), e[i]);
      end
      p = obs;
      cyc(1'b0, 1'($urandom));
      vecs++;
      if (obs !== p || obs !== exp_vec()) begin
        miss++; $display("FAIL gap[%0d]: got %h expected %h", i, obs, p);
      end
    end
    vecs++;
    if (match_count !== 8'd7) begin
      miss++; $display("FAIL ones_count: got %0d expected 7", match_count);
    end
  endtask

  task automatic test_saturate();
    bit b[4] = '{1,1,0,1};
    cyc(1'b0, 1'b0, 1'b1, 4'b1101, 1'b1, 1'b1);
    vecs++;
    if (match_count !== 8'd0 || match_count2 !== 2'd0) begin
      miss++; $display("FAIL sat_clr: got %0d/%0d expected 0/0", match_count, match_count2);
    end
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 4; i++) begin
        cyc(1'b1, b[i]);
        vecs++;
        if (obs !== exp_vec()) begin
          miss++; $display("FAIL sat[%0d.%0d]: got %h expected %h", r, i, obs, exp_vec());
        end
      end
    vecs++;
    if (match_count2 !== 2'd3 || match_count !== 8'd5) begin
      miss++; $display("FAIL sat_value: got %0d/%0d expected 5/3", match_count, match_count2);
    end
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 4'b0, 1'b0, 1'b1);
    vecs++;
    if (obs !== {3'd4, 1'b1, 8'd0, 2'd0, 3'd4, 1'b1} || obs !== exp_vec()) begin
      miss++; $display("FAIL clr_vs_match: got %h expected %h", obs, {3'd4, 1'b1, 8'd0, 2'd0, 3'd4, 1'b1});
    end
  endtask

  task automatic test_async_reset();
    bit b[4] = '{1,0,1,1};
    bit c[4] = '{1,1,0,1};
    cyc(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1);
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 4; i++) cyc(1'b1, b[i]);
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
    vecs++;
    if (state !== 3'd3 || match_count !== 8'd5 || obs !== exp_vec()) begin
      miss++; $display("FAIL pre_reset: got state %0d count %0d expected 3/5", state, match_count);
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (obs !== 18'h0) begin
      miss++; $display("FAIL async_reset: got %h expected %h", obs, 18'h0);
    end
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, c[i]);
      vecs++;
      if (obs !== exp_vec() || state !== 3'(i + 1)) begin
        miss++; $display("FAIL post_reset[%0d]: got %h expected %h (state %0d)", i, obs, exp_vec(), i + 1);
      end
    end
  endtask

  task automatic test_cfg_we();
    bit c[4] = '{1,1,0,1};
    logic [7:0] cnt;
    cyc(1'b1, 1'b1); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    vecs++;
    if (state !== 3'd3) begin
      miss++; $display("FAIL cfg_pre: got state %0d expected 3", state);
    end
    cnt = match_count;
    cyc(1'b1, 1'b1, 1'b1, 4'b1101, 1'b1);
    vecs++;
    if (state !== 3'd0 || match !== 1'b0 || match_count !== cnt || obs !== exp_vec()) begin
      miss++; $display("FAIL cfg_we: got state %0d match %0b count %0d expected 0/0/%0d", state, match, match_count, cnt);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, c[i]);
      vecs++;
      if (obs !== exp_vec() || state !== 3'(i + 1)) begin
        miss++; $display("FAIL cfg_after[%0d]: got %h expected %h (state %0d)", i, obs, exp_vec(), i + 1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 40) == 0,
          4'($urandom), 1'($urandom), ($urandom % 60) == 0);
      vecs++;
      if (obs !== exp_vec()) begin
        miss++; $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_gaps();
    test_saturate();
    test_async_reset();
    test_cfg_we();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
